// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer: op codes, FSM states, helpers.
package hilo_muldiv_ctrl_pkg;

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_step.sv
// One radix-2 restoring divide iteration: shift in a dividend bit, trial-subtract the divisor.
module div_radix2_step (
  input  logic [32:0] i_rem,
  input  logic        i_bit,
  input  logic [31:0] i_dvs,
  output logic [32:0] o_rem,
  output logic        o_qbit
);

  logic [33:0] w_shift;
  logic [33:0] w_diff;

  // Extra top bit keeps the trial difference sign-exact for any divisor.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {2'b00, i_dvs};
  assign o_qbit  = ~w_diff[33];
  assign o_rem   = o_qbit ? w_diff[32:0] : w_shift[32:0];

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer with EX stall and one-cycle HI/LO write.
// Optional MULDIV_DIV0_FAST_EN: divide by zero completes in one cycle instead of 32 iterations.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  md_state_e   r_state, w_nxt;
  logic        r_busy;
  logic [4:0]  r_cnt;
  logic        r_sa, r_sb;
  logic [31:0] r_a, r_b;
  logic [31:0] r_dvd, r_dvs;
  logic [32:0] r_rem;
  logic [31:0] r_hi, r_lo;

  logic        w_accept, w_signed, w_is_div, w_qbit;
  logic [32:0] w_rem_nxt;
  logic [31:0] w_quo;
  logic [63:0] w_prod;

  assign w_accept = (r_state == MD_IDLE) && start && !flush;
  assign w_signed = ~md_op[0];
  assign w_is_div = md_op[1];

  div_radix2_step u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[31]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  assign w_quo = {r_dvd[30:0], w_qbit};
  // Sign-extending both operands to 64 bits gives the right low 64 bits for signed and unsigned.
  assign w_prod = {{32{r_sa}}, r_a} * {{32{r_sb}}, r_b};

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      MD_IDLE: if (w_accept) begin
        if (w_is_div) begin
`ifdef MULDIV_DIV0_FAST_EN
          w_nxt = (src_b == 32'd0) ? MD_DONE : MD_DIV;
`else
          w_nxt = MD_DIV;
`endif
        end else begin
          w_nxt = MD_MUL;
        end
      end
      MD_MUL:  if (r_cnt == 5'(MUL_CYCLES - 1)) w_nxt = MD_DONE;
      MD_DIV:  if (r_cnt == 5'(DIV_ITERS - 1))  w_nxt = MD_DONE;
      MD_DONE: w_nxt = MD_IDLE;
      default: w_nxt = MD_IDLE;
    endcase
    if (flush) w_nxt = MD_IDLE;
  end

  assign stall    = w_accept || (r_state == MD_MUL) || (r_state == MD_DIV);
  assign hilo_we  = (r_state == MD_DONE) && !flush;
  assign busy     = r_busy;
  assign hi_wdata = r_hi;
  assign lo_wdata = r_lo;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= MD_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt != MD_IDLE);
      case (r_state)
        MD_IDLE: if (w_accept) begin
          r_a   <= src_a;
          r_b   <= src_b;
          r_sa  <= w_signed & src_a[31];
          r_sb  <= w_signed & src_b[31];
          r_dvd <= abs32(src_a, w_signed & src_a[31]);
          r_dvs <= abs32(src_b, w_signed & src_b[31]);
          r_rem <= '0;
          r_cnt <= '0;
`ifdef MULDIV_DIV0_FAST_EN
          if (w_is_div && (src_b == 32'd0)) begin
            r_hi <= src_a;
            r_lo <= (w_signed & src_a[31]) ? 32'd1 : 32'hFFFF_FFFF;
          end
`endif
        end
        MD_MUL: begin
          r_cnt <= r_cnt + 5'd1;
          if ((r_cnt == 5'(MUL_CYCLES - 1)) && !flush) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        MD_DIV: begin
          r_cnt <= r_cnt + 5'd1;
          r_rem <= w_rem_nxt;
          r_dvd <= w_quo;
          // Quotient negated on sign mismatch; remainder follows the dividend.
          if ((r_cnt == 5'(DIV_ITERS - 1)) && !flush) begin
            r_lo <= abs32(w_quo, r_sa ^ r_sb);
            r_hi <= abs32(w_rem_nxt[31:0], r_sa);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: directed corner cases plus random ops vs. arithmetic model.
module tb_hilo_muldiv_ctrl;

  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        stall, busy, hilo_we;
  logic [31:0] hi_wdata, lo_wdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int we_last = -1000;
  int we_gap = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  hilo_muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .hilo_we  (hilo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    int              sa, sb;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'b01: begin
        pu = a;
        pu = pu * b;
        return pu;
      end
      2'b11: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        return {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
  endfunction

  // Cycles from accept to the write strobe; also the number of stalled cycles.
  function automatic int latency(input logic [1:0] op, input logic [31:0] b);
    if (!op[1]) return MUL_CYCLES + 1;
`ifdef MULDIV_DIV0_FAST_EN
    if (b == 0) return 1;
`else
    if (b == 0) return 33;
`endif
    return 33;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (resetn && hilo_we) begin
      we_gap  = cyc - we_last;
      we_last = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got hilo_we at cycle %0d want none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("hi_wdata", hi_wdata, e.hi);
        chk("lo_wdata", lo_wdata, e.lo);
        chk("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Call just after a negedge with the EX stage free; returns in the DONE cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] r;
    int          lat, n;
    r   = model(op, a, b);
    lat = latency(op, b);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    e.hi = r[63:32]; e.lo = r[31:0]; e.due = cyc + lat;
    exp_q.push_back(e);
    #1;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
    chk("stall_len", 32'(n), 32'(lat));
    start = 1'b0;
  endtask

  logic [1:0]  d_op [7] = '{2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11};
  logic [31:0] d_a  [7] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h0000_1234};
  logic [31:0] d_b  [7] = '{32'hFFFF_FFFE, 32'h10, 32'hFFFF_FFFF, 32'd2,
                            32'd2, 32'd0, 32'd0};

  initial begin
    int          c, n;
    logic [1:0]  op;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(hilo_we), 0);
    chk("rst_hi", hi_wdata, 0);
    chk("rst_lo", lo_wdata, 0);
    @(negedge clk) resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      do_op(d_op[i], d_a[i], d_b[i]);
      if (i == 1) begin
        #2;
        chk("b2b_gap", 32'(we_gap), 34);
      end
    end

    // Flush a DIV at T+10, then a DIVU accepted at T+11.
    @(negedge clk);
    start = 1'b1; md_op = 2'b10; src_a = 32'd100; src_b = 32'd7; c = cyc;
    while (cyc < c + 10) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_stall", 32'(stall), 0);
    chk("flush_busy", 32'(busy), 0);
    chk("flush_we", 32'(hilo_we), 0);
    chk("flush_cycle", 32'(cyc), 32'(c + 11));
    do_op(2'b11, 32'd1000, 32'd33);

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk);
    start = 1'b1; md_op = 2'b10; src_a = 32'hDEAD_BEEF; src_b = 32'd5; c = cyc;
    while (cyc < c + 5) @(negedge clk);
    #1;
    resetn = 1'b0; start = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_we", 32'(hilo_we), 0);
    chk("midrst_hi", hi_wdata, 0);
    chk("midrst_lo", lo_wdata, 0);
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
    do_op(2'b00, 32'h0001_0000, 32'hFFFF_0000);

    repeat (20) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      @(negedge clk);
      do_op(op, a, b);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
